// File: rtl/alu_multicycle.sv
// Registered execute-stage ALU: 1-cycle logic/arith ops, iterative multiply
// (shift-add) and divide/modulo (restoring), with a start/busy/done handshake.
module alu_multicycle #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] data1,
   input  logic [WIDTH-1:0] data2,
   input  logic [5:0]       operation,
   input  logic [1:0]       ALUOp,
   output logic             busy,
   output logic             done,
   output logic             zero,
   output logic [WIDTH-1:0] aluResult,
   output logic             div_by_zero
);

   localparam logic [5:0] OP_ADD = 6'd1;
   localparam logic [5:0] OP_SUB = 6'd2;
   localparam logic [5:0] OP_AND = 6'd3;
   localparam logic [5:0] OP_OR  = 6'd4;
   localparam logic [5:0] OP_XOR = 6'd5;
   localparam logic [5:0] OP_NOT = 6'd6;
   localparam logic [5:0] OP_SHL = 6'd7;
   localparam logic [5:0] OP_SHR = 6'd8;
   localparam logic [5:0] OP_MUL = 6'd9;
   localparam logic [5:0] OP_DIV = 6'd10;
   localparam logic [5:0] OP_MOD = 6'd11;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   acc_q, acc_d;      // product accumulator / partial remainder
   logic [WIDTH-1:0]   opa_q, opa_d;      // multiplicand / dividend-then-quotient
   logic [WIDTH-1:0]   opb_q, opb_d;      // multiplier / divisor
   logic               is_mod_q, is_mod_d;
   logic               zero_lat_q, zero_lat_d;
   logic               busy_d, done_d, zero_d, dbz_d;
   logic [WIDTH-1:0]   result_d;

   logic               accept, last, zero_in, fast_dbz, div_ge;
   logic [WIDTH-1:0]   fast_res, mul_sum, div_rem, div_quot;
   logic [WIDTH:0]     div_shift;

   // Next-state, datapath and output computation
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      opa_d      = opa_q;
      opb_d      = opb_q;
      is_mod_d   = is_mod_q;
      zero_lat_d = zero_lat_q;
      result_d   = aluResult;
      zero_d     = zero;
      dbz_d      = div_by_zero;
      fast_dbz   = 1'b0;
      fast_res   = data1;

      accept    = start && (state_q == S_IDLE || state_q == S_DONE);
      last      = (cnt_q == CNT_W'(WIDTH - 1));
      zero_in   = (ALUOp == 2'b10) ? (data1 != data2) : (data1 == data2);
      mul_sum   = acc_q + (opb_q[0] ? opa_q : '0);
      div_shift = {acc_q, opa_q[WIDTH-1]};
      div_ge    = (div_shift >= {1'b0, opb_q});
      div_rem   = div_ge ? WIDTH'(div_shift - {1'b0, opb_q}) : div_shift[WIDTH-1:0];
      div_quot  = {opa_q[WIDTH-2:0], div_ge};

      if (ALUOp[0]) begin
         fast_res = data2;
      end else begin
         case (operation)
            OP_ADD:  fast_res = data1 + data2;
            OP_SUB:  fast_res = data1 - data2;
            OP_AND:  fast_res = data1 & data2;
            OP_OR:   fast_res = data1 | data2;
            OP_XOR:  fast_res = data1 ^ data2;
            OP_NOT:  fast_res = ~data1;
            OP_SHL:  fast_res = data1 << data2;
            OP_SHR:  fast_res = data1 >> data2;
            // Only reached on the fast path when data2 is zero
            OP_DIV:  begin fast_res = '1;    fast_dbz = 1'b1; end
            OP_MOD:  begin fast_res = data1; fast_dbz = 1'b1; end
            default: fast_res = data1;
         endcase
      end

      case (state_q)
         S_MUL: begin
            acc_d = mul_sum;
            opa_d = opa_q << 1;
            opb_d = opb_q >> 1;
            if (last) begin
               state_d  = S_DONE;
               result_d = mul_sum;
               zero_d   = zero_lat_q;
               dbz_d    = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DIV: begin
            acc_d = div_rem;
            opa_d = div_quot;
            if (last) begin
               state_d  = S_DONE;
               result_d = is_mod_q ? div_rem : div_quot;
               zero_d   = zero_lat_q;
               dbz_d    = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            if (accept) begin
               cnt_d      = '0;
               zero_lat_d = zero_in;
               if (!ALUOp[0] && operation == OP_MUL) begin
                  state_d = S_MUL;
                  acc_d   = '0;
                  opa_d   = data1;
                  opb_d   = data2;
               end else if (!ALUOp[0] && (operation == OP_DIV || operation == OP_MOD)
                            && data2 != '0) begin
                  state_d  = S_DIV;
                  acc_d    = '0;
                  opa_d    = data1;
                  opb_d    = data2;
                  is_mod_d = (operation == OP_MOD);
               end else begin
                  state_d  = S_DONE;
                  result_d = fast_res;
                  zero_d   = zero_in;
                  dbz_d    = fast_dbz;
               end
            end
         end
      endcase

      busy_d = (state_d == S_MUL) || (state_d == S_DIV);
      done_d = (state_d == S_DONE);
   end

   // State and output registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         acc_q       <= '0;
         opa_q       <= '0;
         opb_q       <= '0;
         is_mod_q    <= 1'b0;
         zero_lat_q  <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         zero        <= 1'b0;
         aluResult   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         opa_q       <= opa_d;
         opb_q       <= opb_d;
         is_mod_q    <= is_mod_d;
         zero_lat_q  <= zero_lat_d;
         busy        <= busy_d;
         done        <= done_d;
         zero        <= zero_d;
         aluResult   <= result_d;
         div_by_zero <= dbz_d;
      end
   end

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: expectations are queued at issue time
// and matched against each done pulse, including latency and busy duration.
module tb_alu_multicycle;

   localparam int unsigned W = 32;

   typedef struct {
      logic [W-1:0] res;
      logic         zero;
      logic         dbz;
      int           lat;
      int           due;
   } exp_t;

   logic         clock, reset, start;
   logic [W-1:0] data1, data2;
   logic [5:0]   operation;
   logic [1:0]   aluop;
   logic         busy, done, zero, div_by_zero;
   logic [W-1:0] aluresult;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   busy_cnt = 0;
   exp_t sb[$];

   alu_multicycle #(.WIDTH(W), .CNT_W(6)) dut (
      .clock(clock), .reset(reset), .start(start), .data1(data1), .data2(data2),
      .operation(operation), .ALUOp(aluop), .busy(busy), .done(done), .zero(zero),
      .aluResult(aluresult), .div_by_zero(div_by_zero)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) cyc++;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic [5:0] op, input logic [1:0] mode,
                                  input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      e.zero = (mode == 2'b10) ? (a != b) : (a == b);
      e.dbz  = 1'b0;
      e.lat  = 1;
      e.due  = 0;
      e.res  = a;
      if (mode[0]) e.res = b;
      else begin
         case (op)
            6'd1: e.res = a + b;
            6'd2: e.res = a - b;
            6'd3: e.res = a & b;
            6'd4: e.res = a | b;
            6'd5: e.res = a ^ b;
            6'd6: e.res = ~a;
            6'd7: e.res = (b >= W) ? '0 : a << b[4:0];
            6'd8: e.res = (b >= W) ? '0 : a >> b[4:0];
            6'd9: begin e.res = a * b; e.lat = W + 1; end
            6'd10: if (b == 0) begin e.res = '1; e.dbz = 1'b1; end
                   else begin e.res = a / b; e.lat = W + 1; end
            6'd11: if (b == 0) begin e.res = a; e.dbz = 1'b1; end
                   else begin e.res = a % b; e.lat = W + 1; end
            default: e.res = a;
         endcase
      end
      return e;
   endfunction

   // Output monitor: every done pulse must match the oldest outstanding op
   always @(negedge clock) begin
      exp_t e;
      if (reset) busy_cnt = 0;
      else begin
         if (busy) busy_cnt++;
         if (done) begin
            if (sb.size() == 0) check("unexpected_done", 1, 0);
            else begin
               e = sb.pop_front();
               check("result", aluresult, e.res);
               check("zero", zero, e.zero);
               check("div_by_zero", div_by_zero, e.dbz);
               check("latency", cyc, e.due);
               check("busy_cycles", busy_cnt, e.lat - 1);
            end
            busy_cnt = 0;
         end
      end
   end

   // Drive one request; inputs are scrambled after acceptance
   task automatic issue(input logic [5:0] op, input logic [1:0] mode,
                        input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      e = model(op, mode, a, b);
      e.due = cyc + e.lat;
      sb.push_back(e);
      operation = op; aluop = mode; data1 = a; data2 = b; start = 1'b1;
      @(negedge clock); #1;
      start = 1'b0;
      data1 = $urandom; data2 = $urandom;
      operation = 6'($urandom_range(1, 11)); aluop = 2'($urandom);
   endtask

   task automatic wait_empty();
      for (int i = 0; i < 100; i++) begin
         if (sb.size() == 0) break;
         @(negedge clock); #1;
      end
      if (sb.size() != 0) begin
         check("timeout", 64'(sb.size()), 0);
         sb.delete();
      end
   endtask

   task automatic run_op(input logic [5:0] op, input logic [1:0] mode,
                         input logic [W-1:0] a, input logic [W-1:0] b);
      issue(op, mode, a, b);
      wait_empty();
   endtask

   initial begin
      logic got_done;
      reset = 1'b1; start = 1'b0; data1 = '0; data2 = '0; operation = '0; aluop = '0;
      repeat (3) @(negedge clock);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_zero", zero, 0);
      check("rst_result", aluresult, 0);
      check("rst_dbz", div_by_zero, 0);
      reset = 1'b0;
      @(negedge clock); #1;

      run_op(6'd1, 2'b00, 5, 7);

      // Back-to-back multiplies, second started on the done cycle
      issue(6'd9, 2'b00, 32'h0000_FFFF, 32'h0001_0001);
      got_done = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (done) begin got_done = 1'b1; break; end
         @(negedge clock); #1;
      end
      check("b2b_done_seen", got_done, 1);
      issue(6'd9, 2'b00, 32'hFFFF_FFFF, 2);
      wait_empty();

      run_op(6'd10, 2'b00, 100, 7);
      run_op(6'd11, 2'b00, 100, 7);
      run_op(6'd10, 2'b00, 5, 0);
      run_op(6'd11, 2'b00, 5, 0);

      // Start while busy is dropped
      issue(6'd9, 2'b00, 123, 456);
      repeat (4) @(negedge clock);
      #1;
      start = 1'b1; operation = 6'd1; aluop = 2'b00; data1 = 1; data2 = 2;
      @(negedge clock); #1;
      start = 1'b0;
      wait_empty();
      repeat (3) @(negedge clock);
      #1;
      check("hold_result", aluresult, 123 * 456);

      // Reset in the middle of a divide
      issue(6'd10, 2'b00, 100, 7);
      repeat (8) @(negedge clock);
      #1;
      reset = 1'b1;
      #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_result", aluresult, 0);
      check("abort_dbz", div_by_zero, 0);
      sb.delete();
      @(negedge clock); #1;
      reset = 1'b0;
      @(negedge clock); #1;
      run_op(6'd2, 2'b00, 9, 4);

      run_op(6'd1, 2'b01, 3, 3);
      run_op(6'd1, 2'b10, 3, 3);
      run_op(6'd9, 2'b11, 7, 9);
      run_op(6'd10, 2'b11, 7, 0);
      run_op(6'd7, 2'b00, 1, 40);
      run_op(6'd7, 2'b00, 1, 31);
      run_op(6'd8, 2'b00, 32'h8000_0000, 31);
      run_op(6'd8, 2'b00, 32'h8000_0000, 32);
      run_op(6'd3, 2'b00, 32'hF0F0_1234, 32'h0FF0_FFFF);
      run_op(6'd4, 2'b00, 32'hF000_0001, 32'h0000_0F00);
      run_op(6'd5, 2'b10, 32'hAAAA_5555, 32'hFFFF_0000);
      run_op(6'd6, 2'b00, 32'h1234_5678, 0);
      run_op(6'd20, 2'b00, 32'hDEAD_BEEF, 1);
      run_op(6'd10, 2'b00, 32'hFFFF_FFFF, 1);
      run_op(6'd11, 2'b00, 7, 100);

      for (int i = 0; i < 16; i++) begin
         logic [W-1:0] a, b;
         a = $urandom;
         b = (i % 4 == 0) ? W'($urandom_range(0, 9)) : $urandom;
         run_op(6'($urandom_range(1, 11)), 2'($urandom), a, b);
      end

      repeat (3) @(negedge clock);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Parametrised, registered successor to the datapath ALU.
- Single-cycle ops complete in one clock. Multiply, divide and modulo run iteratively (shift-add and restoring division) instead of as combinational `*`, `/` and `%`.
- Uses a start/busy/done handshake so the control unit can stall on long ops.
- Sits in the execute stage between the register file/immediate mux and the memory/writeback path.

Parameters:
- WIDTH, 32: datapath width of operands and result. Must be ≥ 4.
- CNT_W, 6: iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; accepted only when busy=0.
- data1  input  WIDTH  operand A.
- data2  input  WIDTH  operand B / immediate.
- operation  input  6  op code.
- ALUOp  input  2  result/branch mode, same encoding as the single-cycle ALU.
- busy  output  1  high while an iterative op is in progress.
- done  output  1  one-cycle pulse when aluResult/zero are valid.
- zero  output  1  branch condition.
- aluResult  output  WIDTH  registered result.
- div_by_zero  output  1  set with done when a div/mod had data2=0.

Behaviour:
- Reset: clock and reset are a single clock with asynchronous, active-high reset. Reset forces state IDLE and counter 0. All outputs are 0: busy, done, zero, aluResult, div_by_zero. Asserting reset mid-operation aborts it; no done is produced.
- States: IDLE, MUL, DIV, DONE. busy=1 only in MUL and DIV. done=1 only in DONE.
- Acceptance:
  - start is sampled when busy=0, i.e. in IDLE or DONE, so back-to-back ops are allowed.
  - On acceptance, data1, data2, operation and ALUOp are latched. Later input changes have no effect.
  - start while busy=1 is ignored; it is not queued.
- zero is computed from the latched operands and registered with done:
  - ALUOp=10: zero = (data1 != data2).
  - All other ALUOp values: zero = (data1 == data2).
- ALUOp=01 or 11: aluResult = latched data2, and the op always takes the 1-cycle path, including codes 9/10/11.
- ALUOp=00 or 10, 1-cycle codes (result registered, then DONE on the next edge, so done rises 1 cycle after acceptance):
  - 1 add, 2 sub: modulo 2^WIDTH.
  - 3 and, 4 or, 5 xor.
  - 6 not: ~data1.
  - 7 shl, 8 shr: logical shifts. Shift amount is the full data2 value; data2 ≥ WIDTH gives 0.
  - Any other code: pass data1.
- Code 9 (mul, ALUOp 00/10):
  - Unsigned shift-add over WIDTH iterations in state MUL.
  - Result is the low WIDTH bits of the product.
  - done asserts WIDTH+1 cycles after acceptance.
- Codes 10 (div) and 11 (mod), ALUOp 00/10:
  - Unsigned restoring division over WIDTH iterations in state DIV.
  - div returns the quotient; mod returns the remainder.
  - done asserts WIDTH+1 cycles after acceptance.
- Divide by zero (code 10/11, data2=0):
  - Skip DIV; go straight to DONE (1-cycle latency) with div_by_zero=1.
  - div returns all-ones; mod returns data1.
- div_by_zero is 0 for every other op.
- Output hold: aluResult, zero and div_by_zero hold their last values through IDLE and while busy. They update only on entry to DONE.
- Counter: counts 0 to WIDTH-1, clears on acceptance, and never wraps while in use.

Test Plan:
- Single-cycle op: start with op=1, 5+7, ALUOp=00 → done exactly 1 cycle later, aluResult=12, zero=0, busy never high.
- Multiply: op=9, 0x0000FFFF × 0x00010001 (WIDTH=32) → busy high for 32 cycles, done at cycle 33, aluResult=0xFFFFFFFF. Then back-to-back op=9, 0xFFFFFFFF × 2 started on the done cycle → 0xFFFFFFFE.
- Divide and modulo: op=10, 100/7 → 14 at cycle 33. op=11, 100%7 → 2. op=10, 5/0 → done at cycle 1, aluResult=0xFFFFFFFF, div_by_zero=1. op=11, 5%0 → aluResult=5.
- Start while busy: during a mul, pulse start with op=1 and change data1/data2 → the mul result is unaffected, no extra done, and the add is lost.
- Reset mid-operation: assert reset at cycle 10 of a div → busy, done and aluResult are 0 immediately (asynchronously). After release, a new op=2, 9-4 → 5 in 1 cycle.
- Branch/ALUOp modes: data1=data2=3 with ALUOp=01 → zero=1, aluResult=3. ALUOp=10 with op=1 → zero=0, aluResult=6. ALUOp=11 with op=9 → 1-cycle latency, aluResult=data2. Shift: op=7, 1<<40 → 0.
